multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle version of the 16-bit CPU.
- Sequences one shared memory port, the 4-entry register file and the single ALU across FETCH/DECODE/EXEC/MEM/WB steps.
- Replaces the combinational main control. Adds a memory ready handshake, a memory-wait watchdog, run/halt control and illegal-opcode trapping.

Parameters:
- MEM_WAIT_MAX, 15: maximum consecutive cycles spent waiting for mem_ready before bus_error is raised.
- HALT_OPCODE, 4'b1111: opcode that stops the processor cleanly.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- reset_n  in  1  synchronous, active-low reset.
- run  in  1  level; a fetch is started only while run=1.
- opcode  in  4  IR[15:12], taken from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory has completed the current request this cycle.
- mem_req  out  1  memory access request.
- mem_write  out  1  1 = write, 0 = read; valid while mem_req=1.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load the instruction register.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if zero=1.
- pc_source  out  1  0 = ALU result, 1 = ALUOut (branch target).
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  00 = register B, 01 = constant 2, 10 = sign-extended imm, 11 = sign-extended imm<<1.
- alu_op  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- reg_dst  out  1  write register select: 1 = IR[7:6], 0 = IR[9:8].
- mem_to_reg  out  1  write data select: 1 = MDR, 0 = ALUOut.
- reg_write  out  1  register file write enable.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- halted  out  1  FSM is in HALT.
- illegal  out  1  sticky; undefined opcode seen.
- bus_error  out  1  sticky; memory watchdog expired.
- state  out  4  current state, for debug.

Behaviour:
- Reset:
  - reset_n=0 at posedge forces state=FETCH(0), wait counter=0, illegal=0, bus_error=0.
  - All outputs are decoded from state and are 0 while reset_n=0.
  - Reset mid-instruction or mid-wait abandons the access; no write strobe may be asserted in the reset cycle.
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, ADDI_EXEC=9, ADDI_WB=10, HALT=11.
- FETCH:
  - run=0: all outputs 0, stay in FETCH.
  - run=1: mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=010.
  - ir_write and pc_write are asserted only in a cycle where mem_ready=1, so PC advances by 2. Next state is DECODE.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=010 (precomputes the branch target into ALUOut).
  - Next state by opcode:
    - 0000/0001/0010/0011/0111 -> R_EXEC.
    - 0101/0110 -> MEM_ADDR.
    - 0100 -> ADDI_EXEC.
    - 1000 -> BRANCH.
    - HALT_OPCODE -> HALT.
    - Any other opcode -> HALT with illegal set.
- R_EXEC:
  - alu_src_a=1, alu_src_b=00.
  - alu_op: 0000 -> 010, 0001 -> 110, 0010 -> 000, 0011 -> 001, 0111 -> 111.
  - Next state is R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1; next FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=010. Next MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ: mem_req=1, i_or_d=1; wait for mem_ready; next MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1; next FETCH.
- MEM_WRITE: mem_req=1, mem_write=1, i_or_d=1; on mem_ready assert instr_done, next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=110, pc_write_cond=1, pc_source=1, instr_done=1; next FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=010; next ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1; next FETCH.
- Zero-wait latency: R-type 4 cycles, ADDI 4, SW 4, LW 5, BEQ 3. Each cycle without mem_ready adds 1 cycle.
- Watchdog:
  - The wait counter increments on each cycle in a memory state with mem_ready=0, and clears on mem_ready=1 or on leaving the state.
  - When the counter reaches MEM_WAIT_MAX with mem_ready still 0: set bus_error, go to HALT, and suppress ir_write/pc_write/reg_write/mem_write in that cycle.
  - mem_ready=1 in the same cycle the limit is reached counts as success.
- HALT: all strobes 0, halted=1; leaves only by reset. Dropping run mid-instruction has no effect until the next FETCH.

Test Plan:
- Reset, run=1, mem_ready=1, opcode=0000 -> states 0,1,6,7,0; R_WB has reg_write=1, reg_dst=1; instr_done pulses once, on cycle 4.
- LW (0101) with mem_ready low 3 cycles in MEM_READ -> 8 cycles total; MEM_WB has mem_to_reg=1 and reg_write=1.
- BEQ (1000): zero=1 -> pc_write_cond=1, pc_source=1 in BRANCH; zero=0 -> same strobes, PC holds PC+2 (checked at CPU level); 3 cycles each.
- mem_ready held 0 in FETCH for MEM_WAIT_MAX=15 cycles -> bus_error=1, halted=1, no ir_write ever asserted; subsequent reset_n=0 clears both flags.
- Opcode 1010 -> illegal=1, halted=1 after DECODE; opcode 1111 -> halted=1 with illegal=0.
- run=0 after reset -> FETCH held, mem_req=0 for 10 cycles; assert reset_n=0 during MEM_WRITE wait -> next state FETCH, mem_write=0.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle 16-bit CPU.
//
// Sequences one shared memory port, the register file and the single ALU
// through FETCH/DECODE/EXEC/MEM/WB steps. Memory accesses wait on a ready
// handshake, guarded by a watchdog. Undefined opcodes trap into HALT.
//
// Ports:
//   clock, reset_n      clock; synchronous active-low reset
//   run                 a fetch is started only while run=1
//   opcode              IR[15:12]
//   zero                ALU zero flag (used by the datapath together with pc_write_cond)
//   mem_ready           memory completes the current request this cycle
//   mem_req/mem_write   memory request and direction
//   i_or_d              memory address select (0 = PC, 1 = ALUOut)
//   ir_write, pc_write, pc_write_cond, pc_source, alu_src_a, alu_src_b, alu_op,
//   reg_dst, mem_to_reg, reg_write   datapath controls
//   instr_done          one-cycle pulse on the last cycle of each instruction
//   halted              FSM sits in HALT
//   illegal, bus_error  sticky trap flags
//   state               current state, for debug
module multicycle_control #(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter logic [3:0]  HALT_OPCODE  = 4'b1111
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       run,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_source,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       instr_done,
  output logic       halted,
  output logic       illegal,
  output logic       bus_error,
  output logic [3:0] state
);

  localparam int unsigned CntW = $clog2(MEM_WAIT_MAX + 1);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StRExec    = 4'd6,
    StRWb      = 4'd7,
    StBranch   = 4'd8,
    StAddiExec = 4'd9,
    StAddiWb   = 4'd10,
    StHalt     = 4'd11
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   wait_q;
  logic              illegal_q, bus_error_q;
  logic              set_illegal, set_bus_error;
  logic              mem_state, waiting, timeout;

  // The branch decision (zero & pc_write_cond) is resolved in the datapath.
  logic unused_zero;
  assign unused_zero = zero;

  assign mem_state = ((state_q == StFetch) && run) || (state_q == StMemRead) ||
                     (state_q == StMemWrite);
  assign waiting   = mem_state && !mem_ready;
  // Fires on the MEM_WAIT_MAX-th consecutive cycle without mem_ready.
  assign timeout   = waiting && (wait_q == CntW'(MEM_WAIT_MAX - 1));

  always_comb begin
    mem_req       = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 3'b000;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    instr_done    = 1'b0;
    halted        = 1'b0;
    state_d       = state_q;
    set_illegal   = 1'b0;
    set_bus_error = 1'b0;

    unique case (state_q)
      StFetch: begin
        if (run) begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          alu_op    = 3'b010;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = StDecode;
          end else if (timeout) begin
            set_bus_error = 1'b1;
            state_d       = StHalt;
          end
        end
      end
      StDecode: begin
        alu_src_b = 2'b11;
        alu_op    = 3'b010;
        if (opcode == HALT_OPCODE) begin
          state_d = StHalt;
        end else begin
          case (opcode)
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111: state_d = StRExec;
            4'b0101, 4'b0110:                            state_d = StMemAddr;
            4'b0100:                                     state_d = StAddiExec;
            4'b1000:                                     state_d = StBranch;
            default: begin
              set_illegal = 1'b1;
              state_d     = StHalt;
            end
          endcase
        end
      end
      StRExec: begin
        alu_src_a = 1'b1;
        case (opcode)
          4'b0001: alu_op = 3'b110;
          4'b0010: alu_op = 3'b000;
          4'b0011: alu_op = 3'b001;
          4'b0111: alu_op = 3'b111;
          default: alu_op = 3'b010;
        endcase
        state_d = StRWb;
      end
      StRWb: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StMemAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 3'b010;
        state_d   = (opcode == 4'b0110) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        if (mem_ready) begin
          state_d = StMemWb;
        end else if (timeout) begin
          set_bus_error = 1'b1;
          state_d       = StHalt;
        end
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StMemWrite: begin
        mem_req   = 1'b1;
        i_or_d    = 1'b1;
        // Write strobe is withheld on the cycle the watchdog gives up.
        mem_write = !timeout;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = StFetch;
        end else if (timeout) begin
          set_bus_error = 1'b1;
          state_d       = StHalt;
        end
      end
      StBranch: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b110;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
        instr_done    = 1'b1;
        state_d       = StFetch;
      end
      StAddiExec: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 3'b010;
        state_d   = StAddiWb;
      end
      StAddiWb: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = StFetch;
      end
      StHalt: begin
        halted = 1'b1;
      end
      default: state_d = StFetch;
    endcase

    // Nothing may strobe during a reset cycle, even mid-access.
    if (!reset_n) begin
      mem_req       = 1'b0;
      mem_write     = 1'b0;
      i_or_d        = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 3'b000;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      instr_done    = 1'b0;
      halted        = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= StFetch;
      wait_q      <= '0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= (waiting && !timeout) ? wait_q + 1'b1 : '0;
      if (set_illegal) begin
        illegal_q <= 1'b1;
      end
      if (set_bus_error) begin
        bus_error_q <= 1'b1;
      end
    end
  end

  assign illegal   = reset_n & illegal_q;
  assign bus_error = reset_n & bus_error_q;
  assign state     = reset_n ? state_q : 4'd0;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a table of per-cycle vectors followed by
// hand-written watchdog and reset corner-case sequences.
module tb_multicycle_control;

  logic       clock = 1'b0;
  logic       reset_n, run, zero, mem_ready;
  logic [3:0] opcode;
  logic       mem_req, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, pc_source;
  logic       alu_src_a, reg_dst, mem_to_reg, reg_write, instr_done, halted, illegal, bus_error;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [3:0] state;

  always #5 clock = ~clock;

  multicycle_control dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .run          (run),
    .opcode       (opcode),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_write    (mem_write),
    .i_or_d       (i_or_d),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .pc_source    (pc_source),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .reg_dst      (reg_dst),
    .mem_to_reg   (mem_to_reg),
    .reg_write    (reg_write),
    .instr_done   (instr_done),
    .halted       (halted),
    .illegal      (illegal),
    .bus_error    (bus_error),
    .state        (state)
  );

  logic [23:0] outs;
  assign outs = {mem_req, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, pc_source,
                 alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, instr_done,
                 halted, illegal, bus_error, state};

  localparam logic [23:0] MREQ   = 24'h800000, MWR  = 24'h400000, IOD   = 24'h200000;
  localparam logic [23:0] IRW    = 24'h100000, PCW  = 24'h080000, PCWC  = 24'h040000;
  localparam logic [23:0] PCSRC  = 24'h020000, SRCA = 24'h010000;
  localparam logic [23:0] B_TWO  = 24'h004000, B_IMM = 24'h008000, B_IMMSH = 24'h00C000;
  localparam logic [23:0] OP_ADD = 24'h001000, OP_SUB = 24'h003000, OP_AND = 24'h000000;
  localparam logic [23:0] OP_OR  = 24'h000800, OP_SLT = 24'h003800;
  localparam logic [23:0] RDST   = 24'h000400, M2R  = 24'h000200, RW    = 24'h000100;
  localparam logic [23:0] DONE   = 24'h000080, HLT  = 24'h000040, ILL   = 24'h000020;
  localparam logic [23:0] BERR   = 24'h000010;

  localparam logic [23:0] S_DEC = 24'd1, S_MADDR = 24'd2, S_MRD = 24'd3, S_MWB = 24'd4;
  localparam logic [23:0] S_MWR = 24'd5, S_REX = 24'd6, S_RWB = 24'd7, S_BR = 24'd8;
  localparam logic [23:0] S_AEX = 24'd9, S_AWB = 24'd10, S_HALT = 24'd11;

  localparam logic [23:0] F_RDY  = MREQ | B_TWO | OP_ADD | IRW | PCW;
  localparam logic [23:0] F_WAIT = MREQ | B_TWO | OP_ADD;
  localparam logic [23:0] DEC    = B_IMMSH | OP_ADD | S_DEC;
  localparam logic [23:0] MADDR  = SRCA | B_IMM | OP_ADD | S_MADDR;

  typedef struct {
    string       name;
    logic        rst;
    logic        rn;
    logic [3:0]  opc;
    logic        z;
    logic        rdy;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  logic [3:0]  r_opc [5];
  logic [23:0] r_aop [5];

  function automatic void add(input string name, input logic rst, input logic rn,
                              input logic [3:0] opc, input logic z, input logic rdy,
                              input logic [23:0] exp);
    vec_t v;
    v.name = name; v.rst = rst; v.rn = rn; v.opc = opc; v.z = z; v.rdy = rdy; v.exp = exp;
    vecs.push_back(v);
  endfunction

  // Drive inputs, compare on the falling edge, then advance one rising edge.
  task automatic step(input string name, input logic rst, input logic rn,
                      input logic [3:0] opc, input logic z, input logic rdy,
                      input logic [23:0] exp);
    reset_n = rst; run = rn; opcode = opc; zero = z; mem_ready = rdy;
    @(negedge clock);
    tests++;
    if (outs !== exp) begin
      fails++;
      $display("FAIL %s: got %06h expected %06h (state got %0d)", name, outs, exp, state);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; run = 1'b0; opcode = 4'd0; zero = 1'b0; mem_ready = 1'b0;
    r_opc = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111};
    r_aop = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT};
    @(posedge clock);
    #1;

    // ---------------- table ----------------
    add("reset_outputs_zero", 0, 1, 4'h0, 0, 1, 24'h0);
    for (int i = 0; i < 5; i++) begin
      add("r_fetch",  1, 1, r_opc[i], 0, 1, F_RDY);
      add("r_decode", 1, 1, r_opc[i], 0, 1, DEC);
      add("r_exec",   1, 1, r_opc[i], 0, 1, SRCA | r_aop[i] | S_REX);
      add("r_wb",     1, 1, r_opc[i], 0, 1, RW | RDST | DONE | S_RWB);
    end
    // LW with three wait cycles in MEM_READ: 8 cycles.
    add("lw_fetch",  1, 1, 4'h5, 0, 1, F_RDY);
    add("lw_decode", 1, 1, 4'h5, 0, 1, DEC);
    add("lw_addr",   1, 1, 4'h5, 0, 1, MADDR);
    for (int i = 0; i < 3; i++) add("lw_read_wait", 1, 1, 4'h5, 0, 0, MREQ | IOD | S_MRD);
    add("lw_read_rdy", 1, 1, 4'h5, 0, 1, MREQ | IOD | S_MRD);
    add("lw_wb",       1, 1, 4'h5, 0, 1, RW | M2R | DONE | S_MWB);
    // SW, zero wait.
    add("sw_fetch",  1, 1, 4'h6, 0, 1, F_RDY);
    add("sw_decode", 1, 1, 4'h6, 0, 1, DEC);
    add("sw_addr",   1, 1, 4'h6, 0, 1, MADDR);
    add("sw_write",  1, 1, 4'h6, 0, 1, MREQ | MWR | IOD | DONE | S_MWR);
    // BEQ taken, then not taken with run dropped mid-instruction.
    add("beq1_fetch",  1, 1, 4'h8, 1, 1, F_RDY);
    add("beq1_decode", 1, 1, 4'h8, 1, 1, DEC);
    add("beq1_branch", 1, 1, 4'h8, 1, 1, SRCA | OP_SUB | PCWC | PCSRC | DONE | S_BR);
    add("beq0_fetch",  1, 1, 4'h8, 0, 1, F_RDY);
    add("beq0_decode", 1, 0, 4'h8, 0, 1, DEC);
    add("beq0_branch", 1, 0, 4'h8, 0, 1, SRCA | OP_SUB | PCWC | PCSRC | DONE | S_BR);
    add("run0_fetch",  1, 0, 4'h8, 0, 1, 24'h0);
    // ADDI, with two fetch wait cycles first.
    add("addi_fetch_wait", 1, 1, 4'h4, 0, 0, F_WAIT);
    add("addi_fetch_wait", 1, 1, 4'h4, 0, 0, F_WAIT);
    add("addi_fetch",      1, 1, 4'h4, 0, 1, F_RDY);
    add("addi_decode",     1, 1, 4'h4, 0, 1, DEC);
    add("addi_exec",       1, 1, 4'h4, 0, 1, SRCA | B_IMM | OP_ADD | S_AEX);
    add("addi_wb",         1, 1, 4'h4, 0, 1, RW | DONE | S_AWB);
    // Illegal opcode traps; reset clears the flag.
    add("ill_fetch",  1, 1, 4'hA, 0, 1, F_RDY);
    add("ill_decode", 1, 1, 4'hA, 0, 1, DEC);
    add("ill_halt",   1, 1, 4'hA, 0, 1, HLT | ILL | S_HALT);
    add("ill_stay",   1, 1, 4'h0, 0, 1, HLT | ILL | S_HALT);
    add("ill_reset",  0, 1, 4'h0, 0, 1, 24'h0);
    add("ill_clear",  1, 0, 4'h0, 0, 1, 24'h0);
    // Clean halt opcode.
    add("hlt_fetch",  1, 1, 4'hF, 0, 1, F_RDY);
    add("hlt_decode", 1, 1, 4'hF, 0, 1, DEC);
    add("hlt_halt",   1, 1, 4'hF, 0, 1, HLT | S_HALT);
    add("hlt_reset",  0, 1, 4'hF, 0, 1, 24'h0);

    foreach (vecs[i]) step(vecs[i].name, vecs[i].rst, vecs[i].rn, vecs[i].opc, vecs[i].z,
                           vecs[i].rdy, vecs[i].exp);

    // ---------------- hand-written sequences ----------------
    // run=0 after reset holds FETCH with no request.
    step("run0_reset", 0, 0, 4'h0, 0, 1, 24'h0);
    for (int i = 0; i < 10; i++) step("run0_hold", 1, 0, 4'h0, 0, 1, 24'h0);

    // FETCH watchdog: 15 cycles without mem_ready, then HALT with bus_error.
    step("wd_fetch_reset", 0, 1, 4'h0, 0, 0, 24'h0);
    for (int i = 0; i < 15; i++) step("wd_fetch_wait", 1, 1, 4'h0, 0, 0, F_WAIT);
    step("wd_fetch_halt", 1, 1, 4'h0, 0, 0, HLT | BERR | S_HALT);
    step("wd_fetch_halt_stay", 1, 1, 4'h0, 0, 1, HLT | BERR | S_HALT);
    step("wd_clear_reset", 0, 1, 4'h0, 0, 0, 24'h0);
    step("wd_cleared", 1, 0, 4'h0, 0, 0, 24'h0);

    // MEM_READ: ready arriving on the limit cycle counts as success.
    step("wd_lw_reset", 0, 1, 4'h5, 0, 1, 24'h0);
    step("wd_lw_fetch", 1, 1, 4'h5, 0, 1, F_RDY);
    step("wd_lw_decode", 1, 1, 4'h5, 0, 1, DEC);
    step("wd_lw_addr", 1, 1, 4'h5, 0, 1, MADDR);
    for (int i = 0; i < 14; i++) step("wd_lw_wait", 1, 1, 4'h5, 0, 0, MREQ | IOD | S_MRD);
    step("wd_lw_rdy_at_limit", 1, 1, 4'h5, 0, 1, MREQ | IOD | S_MRD);
    step("wd_lw_wb", 1, 1, 4'h5, 0, 1, RW | M2R | DONE | S_MWB);
    step("wd_lw_no_error", 1, 0, 4'h5, 0, 1, 24'h0);

    // MEM_WRITE timeout: mem_write withheld on the limit cycle.
    step("wd_sw_reset", 0, 1, 4'h6, 0, 1, 24'h0);
    step("wd_sw_fetch", 1, 1, 4'h6, 0, 1, F_RDY);
    step("wd_sw_decode", 1, 1, 4'h6, 0, 1, DEC);
    step("wd_sw_addr", 1, 1, 4'h6, 0, 1, MADDR);
    for (int i = 0; i < 14; i++) step("wd_sw_wait", 1, 1, 4'h6, 0, 0, MREQ | MWR | IOD | S_MWR);
    step("wd_sw_limit", 1, 1, 4'h6, 0, 0, MREQ | IOD | S_MWR);
    step("wd_sw_halt", 1, 1, 4'h6, 0, 0, HLT | BERR | S_HALT);

    // Reset during a MEM_WRITE wait abandons the store.
    step("rw_reset", 0, 1, 4'h6, 0, 1, 24'h0);
    step("rw_fetch", 1, 1, 4'h6, 0, 1, F_RDY);
    step("rw_decode", 1, 1, 4'h6, 0, 1, DEC);
    step("rw_addr", 1, 1, 4'h6, 0, 1, MADDR);
    step("rw_wait", 1, 1, 4'h6, 0, 0, MREQ | MWR | IOD | S_MWR);
    step("rw_reset_in_wait", 0, 1, 4'h6, 0, 0, 24'h0);
    step("rw_back_to_fetch", 1, 1, 4'h6, 0, 0, F_WAIT);
    for (int i = 0; i < 13; i++) step("rw_counter_cleared", 1, 1, 4'h6, 0, 0, F_WAIT);
    step("rw_fetch_after_wait", 1, 1, 4'h6, 0, 1, F_RDY);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
